// File: rtl/snoop_cache_ctrl.sv
// snoop_cache_ctrl
//   Direct-mapped, write-through cache controller with a simple snooping
//   protocol against one peer cache. Read hits complete from the local
//   array. Read misses and all writes go to main memory over an AR/DR
//   handshake. A transaction aborts if DR has not arrived after TIMEOUT
//   cycles of AR. Peer bus traffic is observed every cycle: a peer write
//   invalidates a matching line, and a peer read demotes exclusive to shared.
//
// Ports
//   SCLK, SRST        clock (rising edge), synchronous active-high reset
//   cpu_req/rw/addr/wdata   CPU request, sampled only when idle
//   cpu_rdata/ready/err     completion: one-cycle ready pulse, err on timeout
//   AR, RW, addr_o, data_o  memory bus request (held until DR)
//   snoop                   broadcast to peer, mirrors AR
//   data_i, DR              memory read data and data-ready
//   peer_snoop/rw/addr      peer cache bus transaction
module snoop_cache_ctrl #(
  parameter int LINES   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic        SCLK,
  input  logic        SRST,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [23:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic        AR,
  output logic        RW,
  output logic        snoop,
  output logic [23:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic        DR,
  input  logic        peer_snoop,
  input  logic        peer_rw,
  input  logic [23:0] peer_addr
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 24;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W;
  localparam int CNT_W  = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOOKUP  = 3'd1;
  localparam logic [2:0] ST_BUS_RD  = 3'd2;
  localparam logic [2:0] ST_BUS_WR  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [1:0] LS_INV  = 2'b00;
  localparam logic [1:0] LS_EXCL = 2'b01;
  localparam logic [1:0] LS_SHRD = 2'b10;

  logic [2:0]        state;
  logic [CNT_W-1:0]  bus_cnt;

  // Latched CPU request
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // Line storage
  logic [1:0]        line_stat [LINES];
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [DATA_W-1:0] line_data [LINES];

  logic [IDX_W-1:0]  lat_idx;
  logic [TAG_W-1:0]  lat_tag;
  logic [IDX_W-1:0]  peer_idx;
  logic [TAG_W-1:0]  peer_tag;
  logic              hit;
  logic              peer_hit;
  logic              fill_en;
  logic              wr_upd_en;

  assign lat_idx  = lat_addr[IDX_W-1:0];
  assign lat_tag  = lat_addr[ADDR_W-1:IDX_W];
  assign peer_idx = peer_addr[IDX_W-1:0];
  assign peer_tag = peer_addr[ADDR_W-1:IDX_W];

  assign snoop = AR;

  // Hit is re-evaluated in BUS_WR at DR time, so a line invalidated by the
  // peer while the write was on the bus is not updated (no allocate).
  always_comb begin
    hit       = (line_stat[lat_idx] != LS_INV) && (line_tag[lat_idx] == lat_tag);
    peer_hit  = peer_snoop && (line_stat[peer_idx] != LS_INV) &&
                (line_tag[peer_idx] == peer_tag);
    fill_en   = (state == ST_BUS_RD) && AR && DR;
    wr_upd_en = (state == ST_BUS_WR) && AR && DR && hit;
  end

  // Request capture: only in IDLE, so requests in other states are dropped
  always_ff @(posedge SCLK) begin
    if (state == ST_IDLE && cpu_req) begin
      lat_rw    <= cpu_rw;
      lat_addr  <= cpu_addr;
      lat_wdata <= cpu_wdata;
    end
  end

  // Tag/data array: written only on a completed fill or a write hit
  always_ff @(posedge SCLK) begin
    if (fill_en) begin
      line_tag[lat_idx]  <= lat_tag;
      line_data[lat_idx] <= data_i;
    end
    if (wr_upd_en) begin
      line_data[lat_idx] <= lat_wdata;
    end
  end

  // Control FSM, bus outputs and line status
  always_ff @(posedge SCLK) begin
    if (SRST) begin
      state     <= ST_IDLE;
      bus_cnt   <= '0;
      AR        <= 1'b0;
      RW        <= 1'b0;
      addr_o    <= '0;
      data_o    <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      for (int i = 0; i < LINES; i++) begin
        line_stat[i] <= LS_INV;
      end
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;

      // Peer snoop is applied first; an own fill/update to the same index
      // later in this block overrides it (last nonblocking write wins).
      if (peer_hit) begin
        if (!peer_rw) begin
          line_stat[peer_idx] <= LS_INV;
        end else if (line_stat[peer_idx] == LS_EXCL) begin
          line_stat[peer_idx] <= LS_SHRD;
        end
      end

      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            state <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (lat_rw && hit) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= line_data[lat_idx];
            state     <= ST_IDLE;
          end else begin
            AR      <= 1'b1;
            RW      <= lat_rw;
            addr_o  <= lat_addr;
            bus_cnt <= '0;
            if (!lat_rw) begin
              data_o <= lat_wdata;
            end
            state <= lat_rw ? ST_BUS_RD : ST_BUS_WR;
          end
        end

        ST_BUS_RD, ST_BUS_WR: begin
          if (DR) begin
            AR        <= 1'b0;
            cpu_ready <= 1'b1;
            bus_cnt   <= '0;
            state     <= ST_RELEASE;
            if (state == ST_BUS_RD) begin
              cpu_rdata          <= data_i;
              line_stat[lat_idx] <= LS_SHRD;
            end else if (hit) begin
              line_stat[lat_idx] <= LS_EXCL;
            end
          end else if (bus_cnt == CNT_LAST) begin
            // Abort: cache untouched, error reported with the ready pulse
            AR        <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            bus_cnt   <= '0;
            state     <= ST_RELEASE;
          end else begin
            bus_cnt <= bus_cnt + 1'b1;
          end
        end

        // One dead cycle so a DR still held high is not taken as a new response
        ST_RELEASE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
module tb_snoop_cache_ctrl;

  logic        SCLK = 1'b0;
  logic        SRST;
  logic        cpu_req;
  logic        cpu_rw;
  logic [23:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        AR;
  logic        RW;
  logic        snoop;
  logic [23:0] addr_o;
  logic [31:0] data_o;
  logic [31:0] data_i      = 32'h0;
  logic        DR          = 1'b0;
  logic        peer_snoop  = 1'b0;
  logic        peer_rw     = 1'b0;
  logic [23:0] peer_addr   = 24'h0;

  snoop_cache_ctrl #(.LINES(16), .TIMEOUT(15)) dut (
    .SCLK      (SCLK),
    .SRST      (SRST),
    .cpu_req   (cpu_req),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .AR        (AR),
    .RW        (RW),
    .snoop     (snoop),
    .addr_o    (addr_o),
    .data_o    (data_o),
    .data_i    (data_i),
    .DR        (DR),
    .peer_snoop(peer_snoop),
    .peer_rw   (peer_rw),
    .peer_addr (peer_addr)
  );

  always #5 SCLK = ~SCLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        rchk;
  } sb_t;
  sb_t sb_q[$];

  // Memory/peer model configuration, written by the stimulus process
  int          dr_lat      = 0;
  logic [31:0] rd_data     = 32'h0;
  logic        exp_bus_rw  = 1'b1;
  logic [23:0] exp_bus_addr = 24'h0;
  logic [31:0] exp_bus_data = 32'h0;
  logic        snoop_on_dr = 1'b0;
  logic [23:0] snp_fill_addr = 24'h0;
  logic        snp_rw      = 1'b0;
  logic [23:0] snp_addr    = 24'h0;
  int          snp_req_n   = 0;

  // Memory/peer model state, written only by the responder
  int   snp_done_n = 0;
  bit   snp_pulse  = 0;
  int   ar_cnt     = 0;
  int   idle_n     = 0;
  int   ar_total   = 0;
  int   bus_bad_n  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory and peer responder; acts on the falling edge so the DUT sees
  // stable inputs at the next rising edge.
  always @(negedge SCLK) begin
    if (snp_pulse) begin
      peer_snoop = 1'b0;
      snp_pulse  = 0;
    end
    if (snp_req_n != snp_done_n) begin
      peer_snoop = 1'b1;
      peer_rw    = snp_rw;
      peer_addr  = snp_addr;
      snp_done_n = snp_req_n;
      snp_pulse  = 1;
    end
    if (AR === 1'b1) begin
      ar_total++;
      ar_cnt++;
      idle_n = 0;
      if (RW !== exp_bus_rw || addr_o !== exp_bus_addr || snoop !== 1'b1 ||
          (!exp_bus_rw && data_o !== exp_bus_data))
        bus_bad_n++;
      if (dr_lat != 0 && ar_cnt == dr_lat) begin
        DR     = 1'b1;
        data_i = rd_data;
        if (snoop_on_dr) begin
          peer_snoop = 1'b1;
          peer_rw    = 1'b0;
          peer_addr  = snp_fill_addr;
          snp_pulse  = 1;
        end
      end
    end else begin
      ar_cnt = 0;
      idle_n++;
      // DR lingers through the RELEASE cycle to exercise level sensitivity
      if (idle_n >= 2) DR = 1'b0;
    end
  end

  task automatic cpu_op(input string nm, input logic rw, input logic [23:0] addr,
                        input logic [31:0] wdata, input int dlat, input logic [31:0] rdat,
                        input int exp_lat, input int exp_ar, input logic exp_err,
                        input logic stray_req, input logic snp_fill);
    sb_t e;
    int  ar0, bad0, lat;
    bit  got;
    dr_lat       = dlat;
    rd_data      = rdat;
    exp_bus_rw   = rw;
    exp_bus_addr = addr;
    exp_bus_data = wdata;
    snoop_on_dr  = snp_fill;
    e.rdata = rdat;
    e.err   = exp_err;
    e.rchk  = rw && !exp_err;
    sb_q.push_back(e);
    ar0  = ar_total;
    bad0 = bus_bad_n;
    @(posedge SCLK); #1;
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata;
    got = 0; lat = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(posedge SCLK); #1;
      cpu_req = stray_req && (i == 5);
      if (cpu_ready === 1'b1) begin
        got = 1;
        lat = i;
      end
    end
    cpu_req = 1'b0;
    e = sb_q.pop_front();
    if (got) begin
      chk_eq({nm, "_err"}, cpu_err, e.err);
      if (e.rchk) chk_eq({nm, "_rdata"}, cpu_rdata, e.rdata);
    end else begin
      chk_eq({nm, "_ready_timeout"}, 32'd0, 32'd1);
    end
    chk_eq({nm, "_latency"}, lat, exp_lat);
    @(posedge SCLK); #1;
    chk_eq({nm, "_ready_pulse"}, {cpu_ready, cpu_err}, 2'b00);
    repeat (2) @(posedge SCLK);
    #1;
    chk_eq({nm, "_ar_cycles"}, ar_total - ar0, exp_ar);
    chk_eq({nm, "_bus_stable"}, bus_bad_n - bad0, 0);
    snoop_on_dr = 1'b0;
  endtask

  task automatic peer_op(input logic rw, input logic [23:0] a);
    snp_rw   = rw;
    snp_addr = a;
    snp_req_n++;
    repeat (3) @(posedge SCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar_seen, rdy_seen, nz;
    SRST = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge SCLK);
    #1;
    chk_eq("rst_bus", {AR, RW, snoop}, 3'b000);
    chk_eq("rst_ready", {cpu_ready, cpu_err}, 2'b00);
    chk_eq("rst_rdata", cpu_rdata, 32'h0);
    chk_eq("rst_addr_o", addr_o, 32'h0);
    chk_eq("rst_data_o", data_o, 32'h0);
    chk_eq("rst_stat3", dut.line_stat[3], 2'b00);
    SRST = 1'b0;
    repeat (2) @(posedge SCLK);

    // Read miss, DR on 3rd AR cycle; line 3 becomes shared
    cpu_op("rd_miss", 1'b1, 24'h000123, 32'h0, 3, 32'hCAFE0001, 5, 3, 1'b0, 1'b0, 1'b0);
    chk_eq("stat3_after_fill", dut.line_stat[3], 2'b10);
    // Read hit, no bus
    cpu_op("rd_hit", 1'b1, 24'h000123, 32'h0, 0, 32'hCAFE0001, 2, 0, 1'b0, 1'b0, 1'b0);
    // Write hit, write-through; line becomes exclusive
    cpu_op("wr_hit", 1'b0, 24'h000123, 32'h5, 2, 32'h0, 4, 2, 1'b0, 1'b0, 1'b0);
    chk_eq("stat3_after_wr", dut.line_stat[3], 2'b01);
    cpu_op("rd_after_wr", 1'b1, 24'h000123, 32'h0, 0, 32'h5, 2, 0, 1'b0, 1'b0, 1'b0);

    // Peer traffic
    peer_op(1'b0, 24'h000223);
    chk_eq("snp_tag_mismatch", dut.line_stat[3], 2'b01);
    peer_op(1'b1, 24'h000123);
    chk_eq("snp_rd_excl", dut.line_stat[3], 2'b10);
    peer_op(1'b1, 24'h000123);
    chk_eq("snp_rd_shrd", dut.line_stat[3], 2'b10);
    peer_op(1'b0, 24'h000123);
    chk_eq("snp_inval", dut.line_stat[3], 2'b00);
    cpu_op("rd_after_inv", 1'b1, 24'h000123, 32'h0, 1, 32'h11112222, 3, 1, 1'b0, 1'b0, 1'b0);

    // Peer invalidate of old line in the same cycle as own fill of new tag
    snp_fill_addr = 24'h000123;
    cpu_op("rd_fill_snp", 1'b1, 24'h000223, 32'h0, 2, 32'h0BADF00D, 4, 2, 1'b0, 1'b0, 1'b1);
    chk_eq("stat3_fill_snp", dut.line_stat[3], 2'b10);
    cpu_op("rd_hit_new", 1'b1, 24'h000223, 32'h0, 0, 32'h0BADF00D, 2, 0, 1'b0, 1'b0, 1'b0);

    // Write miss: no allocate
    cpu_op("wr_miss", 1'b0, 24'h000045, 32'h0000DEAD, 1, 32'h0, 3, 1, 1'b0, 1'b0, 1'b0);
    chk_eq("stat5_no_alloc", dut.line_stat[5], 2'b00);

    // Timeout with a stray request while busy
    cpu_op("timeout", 1'b1, 24'h000077, 32'h0, 0, 32'h0, 17, 15, 1'b1, 1'b1, 1'b0);
    chk_eq("stat7_timeout", dut.line_stat[7], 2'b00);
    chk_eq("stat3_timeout", dut.line_stat[3], 2'b10);

    // Reset during BUS_RD
    dr_lat = 0; exp_bus_rw = 1'b1; exp_bus_addr = 24'h000099;
    @(posedge SCLK); #1;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 24'h000099;
    @(posedge SCLK); #1;
    cpu_req = 1'b0;
    ar_seen = 0;
    for (int i = 0; i < 10 && ar_seen == 0; i++) begin
      @(posedge SCLK); #1;
      if (AR === 1'b1) ar_seen = 1;
    end
    chk_eq("rst_mid_ar_up", ar_seen, 1);
    repeat (3) @(posedge SCLK);
    #1;
    SRST = 1'b1;
    @(posedge SCLK); #1;
    chk_eq("rst_mid_ar_drop", {AR, snoop}, 2'b00);
    SRST = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge SCLK); #1;
      if (cpu_ready !== 1'b0) rdy_seen++;
    end
    chk_eq("rst_mid_no_ready", rdy_seen, 0);
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.line_stat[i] != 2'b00) nz++;
    chk_eq("rst_mid_all_inv", nz, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snoop_cache_ctrl.md
SNOOP_CACHE_CTRL -- requirements
Module: snoop_cache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 16, meaning number of direct-mapped lines (power of 2, index = addr[log2(LINES)-1:0], tag = remaining upper addr bits).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning maximum cycles AR is held awaiting DR before abort.
REQ-003 SHALL have port SCLK  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port SRST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cpu_req  in  1  CPU request strobe, sampled only in IDLE.
REQ-006 SHALL have port cpu_rw  in  1  1 = read, 0 = write.
REQ-007 SHALL have port cpu_addr  in  24  CPU address.
REQ-008 SHALL have port cpu_wdata  in  32  CPU write data.
REQ-009 SHALL have port cpu_rdata  out  32  read result, valid while cpu_ready = 1.
REQ-010 SHALL have port cpu_ready  out  1  one-cycle completion pulse.
REQ-011 SHALL have port cpu_err  out  1  one-cycle pulse with cpu_ready on bus timeout.
REQ-012 SHALL have port AR  out  1  bus access request to main memory.
REQ-013 SHALL have port RW  out  1  bus direction, 1 = read, 0 = write.
REQ-014 SHALL have port snoop  out  1  broadcast to peer cache; equals AR.
REQ-015 SHALL have port addr_o  out  24  bus address.
REQ-016 SHALL have port data_o  out  32  bus write data.
REQ-017 SHALL have port data_i  in  32  bus read data from memory.
REQ-018 SHALL have port DR  in  1  memory data-ready.
REQ-019 SHALL have ports peer_snoop (in, 1), peer_rw (in, 1), peer_addr (in, 24): peer cache bus transaction, observed every cycle.

Function
REQ-020 Each line SHALL hold tag, 32-bit data, 2-bit status: 00 invalid, 01 exclusive, 10 shared.
REQ-021 FSM states SHALL be IDLE, LOOKUP, BUS_RD, BUS_WR, RELEASE.
REQ-022 IDLE: cpu_req = 1 SHALL latch cpu_rw/addr/wdata and go to LOOKUP next cycle.
REQ-023 LOOKUP: hit = status != 00 and tag match.
REQ-024 Read hit SHALL assert cpu_ready with cpu_rdata = line data in the LOOKUP cycle +1 (latency 2 from cpu_req) and return to IDLE.
REQ-025 Read miss SHALL go to BUS_RD: AR = 1, RW = 1, addr_o = latched addr.
REQ-026 Any write (hit or miss) SHALL go to BUS_WR: AR = 1, RW = 0, addr_o = addr, data_o = wdata (write-through).
REQ-027 AR/RW/addr_o/data_o SHALL remain stable until DR = 1 sampled while AR = 1.
REQ-028 On DR in BUS_RD: line filled with data_i and tag, status 10, cpu_rdata = data_i, cpu_ready pulse.
REQ-029 On DR in BUS_WR: on hit, line data updated and status 01; on miss, no allocate; cpu_ready pulse.
REQ-030 After DR, FSM SHALL enter RELEASE for one cycle with AR = 0 and ignore DR, then IDLE; DR is level-sensitive and may remain high.
REQ-031 A 4-bit-min cycle counter SHALL count while AR = 1; reaching TIMEOUT without DR SHALL drop AR, pulse cpu_ready and cpu_err, leave the cache unchanged, go to RELEASE.
REQ-032 Peer snoop, any state: peer_snoop = 1 and matching valid line -> peer_rw = 0 sets status 00; peer_rw = 1 changes 01 to 10, leaves 10 unchanged.
REQ-033 Same-cycle peer invalidate and own fill/update to same index SHALL apply snoop first, own update last.
REQ-034 cpu_req outside IDLE SHALL be ignored; no queuing.
REQ-035 cpu_ready and cpu_err SHALL never assert for more than one consecutive cycle.

Reset
REQ-036 SRST SHALL force IDLE, all statuses 00, counter 0, AR/RW/snoop/cpu_ready/cpu_err 0, cpu_rdata/addr_o/data_o 0.
REQ-037 SRST mid-transaction SHALL drop AR the next cycle and discard the request with no cpu_ready.

Verification
REQ-038 Read miss 0x000123, DR after 3 cycles, data_i 0xCAFE0001 -> AR high 3 cycles, RW = 1; cpu_rdata 0xCAFE0001; line 3 status 10.
REQ-039 Repeat read 0x000123 -> cpu_ready 2 cycles after cpu_req, AR stays 0.
REQ-040 Write 0x000123 data 0x5 -> AR, RW = 0, data_o 0x5; after DR, line 3 status 01, next read returns 0x5 without bus.
REQ-041 peer_snoop = 1, peer_rw = 0, peer_addr 0x000123 -> line 3 status 00; next read misses.
REQ-042 Read miss with DR held 0 -> AR drops after 15 cycles; cpu_ready and cpu_err pulse together; cache unchanged.
REQ-043 SRST during BUS_RD -> AR = 0 next cycle, no cpu_ready, all lines invalid.
